comp_weight_buffer: RTL and testbench
=====================================

// Module: comp_weight_buffer
// PURPOSE
//  Downstream of the weight pre-processing unit during weight load. Registers each reduced weight
//  into a weight-memory write port and collects compensation entries (row, 3-bit weight) per
//  column. Each column holds at most COMP_DEPTH entries and is sealed on the column's last row.
//  After load, the compensation array controller reads each column's entry set.
// PARAMETERS
//  NUM_COL     8  columns; column index = Weight_Mem_Address[5:3]
//  NUM_ROW     8  rows per column; row index = Weight_Mem_Address[2:0]
//  COMP_DEPTH  3  compensation slots per column
//  RW_W        5  reduced weight width
//  CW_W        3  compensation weight width
// PORTS
//  clk                    in   1   clock
//  rst                    in   1   synchronous active-high reset
//  wr_valid               in   1   this cycle's pre-processor outputs are valid
//  Reduced_Weight         in   5   reduced weight for Weight_Mem_Address
//  Weight_Mem_Address     in   6   {col[2:0], row[2:0]}
//  Compensation_Weight    in   3   compensation magnitude
//  Compensation_Row       in   3   row of compensation entry
//  Compensation_out_valid in   1   compensation entry present (qualified by wr_valid)
//  change_col             in   1   last row of current column (qualified by wr_valid)
//  clear                  in   1   drop all entries and seals; start a new load
//  wmem_we                out  1   weight memory write enable
//  wmem_addr              out  6   weight memory address
//  wmem_data              out  5   weight memory data
//  rd_en                  in   1   read request for rd_col
//  rd_col                 in   3   column to read
//  rd_valid               out  1   read data valid
//  rd_count               out  2   number of entries in the column (0..COMP_DEPTH)
//  rd_rows                out  9   {slot2,slot1,slot0} rows; unused slots read 0
//  rd_weights             out  9   {slot2,slot1,slot0} weights; unused slots read 0
//  rd_sealed              out  1   the read column was sealed
//  all_sealed             out  1   all NUM_COL columns sealed
//  overflow               out  1   sticky: entry dropped (column full or already sealed)
// BEHAVIOUR
//  Reset: every output 0; all counts, slots and seal bits 0. clear has the same effect on
//   counts, slots, seals and overflow. clear does not reset the wmem_* or rd_* pipelines.
//  Write path, latency 1: wmem_we <= wr_valid. On wr_valid, wmem_addr <= Weight_Mem_Address
//   and wmem_data <= Reduced_Weight; otherwise these hold. Not gated by clear.
//  Entry capture: on wr_valid && Compensation_out_valid, with c = Weight_Mem_Address[5:3]:
//   - If count[c] < COMP_DEPTH and !sealed[c]: slot[c][count[c]] <= {Compensation_Row,
//     Compensation_Weight}; count[c]++.
//   - Otherwise: entry dropped; overflow <= 1 (sticky until rst/clear).
//  Slots fill in arrival order (slot0 first) and are never reordered.
//  Seal: wr_valid && change_col sets sealed[c]. When an entry and a seal arrive together,
//   capture is evaluated against the pre-seal state, so the entry is stored.
//  all_sealed is registered: it is 1 the cycle after the last seal bit is set.
//  Read, latency 1: rd_en at cycle N -> rd_valid=1 at N+1 with count, slots and seal of rd_col
//   sampled at N, before any same-cycle write. rd_valid=0 when rd_en was 0; the data then holds.
//   A read of an unsealed column is legal and returns rd_sealed=0.
//  Simultaneous events:
//   - clear wins over wr_valid capture and seal in the same cycle.
//   - A read in the same cycle as clear returns pre-clear contents.
//  Mid-operation reset: rst clears everything next edge; partially filled columns are lost.
//  Counts saturate at COMP_DEPTH and never wrap.
// TESTING
//  1 Reset: assert rst 2 cycles -> wmem_we=0, rd_valid=0, all_sealed=0, overflow=0.
//  2 Pass-through: wr_valid, addr 6'd13, RW 5'h1A -> next cycle wmem_we=1, addr 13, data 1A.
//  3 Fill col 2: entries at rows 1,4,6, weights 3,5,7; seal at addr 23; read col 2 ->
//    count=3, rows={6,4,1}, weights={7,5,3}, sealed=1.
//  4 Overflow: 4th entry into col 2 -> not stored, overflow=1, count stays 3.
//  5 Entry and change_col together at addr 7 (row 2, weight 4) -> stored, col 0 sealed.
//    A later entry to col 0 -> dropped, overflow=1.
//  6 Seal cols 0-7 -> all_sealed=1 one cycle after the last seal. clear together with an
//    entry to col 5 -> col 5 count=0, all_sealed=0 next cycle.

Source files
------------

// File: rtl/comp_weight_buffer.sv
// comp_weight_buffer: registers reduced weights into the weight memory and collects per-column compensation entries.
module comp_weight_buffer #(
  parameter int NUM_COL    = 8,
  parameter int NUM_ROW    = 8,
  parameter int COMP_DEPTH = 3,
  parameter int RW_W       = 5,
  parameter int CW_W       = 3
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  wr_valid,
  input  logic [RW_W-1:0]                       Reduced_Weight,
  input  logic [$clog2(NUM_COL*NUM_ROW)-1:0]    Weight_Mem_Address,
  input  logic [CW_W-1:0]                       Compensation_Weight,
  input  logic [$clog2(NUM_ROW)-1:0]            Compensation_Row,
  input  logic                                  Compensation_out_valid,
  input  logic                                  change_col,
  input  logic                                  clear,
  output logic                                  wmem_we,
  output logic [$clog2(NUM_COL*NUM_ROW)-1:0]    wmem_addr,
  output logic [RW_W-1:0]                       wmem_data,
  input  logic                                  rd_en,
  input  logic [$clog2(NUM_COL)-1:0]            rd_col,
  output logic                                  rd_valid,
  output logic [$clog2(COMP_DEPTH+1)-1:0]       rd_count,
  output logic [COMP_DEPTH*$clog2(NUM_ROW)-1:0] rd_rows,
  output logic [COMP_DEPTH*CW_W-1:0]            rd_weights,
  output logic                                  rd_sealed,
  output logic                                  all_sealed,
  output logic                                  overflow
);
  localparam int RI = $clog2(NUM_ROW);
  localparam int CI = $clog2(NUM_COL);
  localparam int NW = $clog2(COMP_DEPTH+1);
  localparam int SW = RI + CW_W;
  logic [NW-1:0]      r_cnt  [NUM_COL];
  logic [SW-1:0]      r_slot [NUM_COL][COMP_DEPTH];
  logic [NUM_COL-1:0] r_seal;
  logic [CI-1:0]      w_col;
  logic               w_ok;
  logic [COMP_DEPTH*RI-1:0]   w_rows;
  logic [COMP_DEPTH*CW_W-1:0] w_wts;
  assign w_col = Weight_Mem_Address[RI +: CI];
  assign w_ok  = (r_cnt[w_col] < NW'(COMP_DEPTH)) && !r_seal[w_col];
  // slots fill in order from reset/clear values, so unused slots already read 0
  always_comb begin
    w_rows = '0;
    w_wts  = '0;
    for (int i = 0; i < COMP_DEPTH; i++) begin
      w_rows[i*RI +: RI]   = r_slot[rd_col][i][SW-1:CW_W];
      w_wts[i*CW_W +: CW_W] = r_slot[rd_col][i][CW_W-1:0];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wmem_we    <= 1'b0;
      wmem_addr  <= '0;
      wmem_data  <= '0;
      rd_valid   <= 1'b0;
      rd_count   <= '0;
      rd_rows    <= '0;
      rd_weights <= '0;
      rd_sealed  <= 1'b0;
      all_sealed <= 1'b0;
      overflow   <= 1'b0;
      r_seal     <= '0;
      for (int i = 0; i < NUM_COL; i++) begin
        r_cnt[i] <= '0;
        for (int j = 0; j < COMP_DEPTH; j++) r_slot[i][j] <= '0;
      end
    end else begin
      wmem_we  <= wr_valid;
      rd_valid <= rd_en;
      if (wr_valid) begin
        wmem_addr <= Weight_Mem_Address;
        wmem_data <= Reduced_Weight;
      end
      if (rd_en) begin
        rd_count   <= r_cnt[rd_col];
        rd_rows    <= w_rows;
        rd_weights <= w_wts;
        rd_sealed  <= r_seal[rd_col];
      end
      if (clear) begin
        all_sealed <= 1'b0;
        overflow   <= 1'b0;
        r_seal     <= '0;
        for (int i = 0; i < NUM_COL; i++) begin
          r_cnt[i] <= '0;
          for (int j = 0; j < COMP_DEPTH; j++) r_slot[i][j] <= '0;
        end
      end else begin
        all_sealed <= &r_seal;
        if (wr_valid && Compensation_out_valid) begin
          if (w_ok) begin
            r_slot[w_col][r_cnt[w_col]] <= {Compensation_Row, Compensation_Weight};
            r_cnt[w_col] <= r_cnt[w_col] + 1'b1;
          end else begin
            overflow <= 1'b1;
          end
        end
        if (wr_valid && change_col) r_seal[w_col] <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_comp_weight_buffer.sv
// tb_comp_weight_buffer: directed stimulus with queued expectations checked by a negedge monitor.
module tb_comp_weight_buffer;
  logic       clk = 0;
  logic       rst;
  logic       wr_valid;
  logic [4:0] Reduced_Weight;
  logic [5:0] Weight_Mem_Address;
  logic [2:0] Compensation_Weight;
  logic [2:0] Compensation_Row;
  logic       Compensation_out_valid;
  logic       change_col;
  logic       clear;
  logic       wmem_we;
  logic [5:0] wmem_addr;
  logic [4:0] wmem_data;
  logic       rd_en;
  logic [2:0] rd_col;
  logic       rd_valid;
  logic [1:0] rd_count;
  logic [8:0] rd_rows;
  logic [8:0] rd_weights;
  logic       rd_sealed;
  logic       all_sealed;
  logic       overflow;
  int tests = 0;
  int fails = 0;
  logic [10:0] wq[$];
  logic [20:0] rq_exp[$];

  comp_weight_buffer dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .Reduced_Weight(Reduced_Weight),
    .Weight_Mem_Address(Weight_Mem_Address), .Compensation_Weight(Compensation_Weight),
    .Compensation_Row(Compensation_Row), .Compensation_out_valid(Compensation_out_valid),
    .change_col(change_col), .clear(clear), .wmem_we(wmem_we), .wmem_addr(wmem_addr),
    .wmem_data(wmem_data), .rd_en(rd_en), .rd_col(rd_col), .rd_valid(rd_valid),
    .rd_count(rd_count), .rd_rows(rd_rows), .rd_weights(rd_weights), .rd_sealed(rd_sealed),
    .all_sealed(all_sealed), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && wmem_we) begin
      if (wq.size() == 0) chk("wmem_unexpected", {21'd0, wmem_addr, wmem_data}, 32'hFFFF_FFFF);
      else chk("wmem", {21'd0, wmem_addr, wmem_data}, {21'd0, wq.pop_front()});
    end
    if (!rst && rd_valid) begin
      if (rq_exp.size() == 0) chk("rd_unexpected", {11'd0, rd_count, rd_rows, rd_weights, rd_sealed}, 32'hFFFF_FFFF);
      else chk("rd", {11'd0, rd_count, rd_rows, rd_weights, rd_sealed}, {11'd0, rq_exp.pop_front()});
    end
  end

  task automatic idle();
    wr_valid = 0; Reduced_Weight = 0; Weight_Mem_Address = 0; Compensation_Weight = 0;
    Compensation_Row = 0; Compensation_out_valid = 0; change_col = 0; clear = 0;
    rd_en = 0; rd_col = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic wr(input logic [5:0] a, input logic [4:0] w, input logic cv,
                    input logic [2:0] cr, input logic [2:0] cw, input logic chg);
    wr_valid = 1; Weight_Mem_Address = a; Reduced_Weight = w;
    Compensation_out_valid = cv; Compensation_Row = cr; Compensation_Weight = cw; change_col = chg;
    wq.push_back({a, w});
  endtask

  task automatic rq(input logic [2:0] c, input logic [1:0] n, input logic [8:0] rows,
                    input logic [8:0] wts, input logic s);
    rd_en = 1; rd_col = c;
    rq_exp.push_back({n, rows, wts, s});
  endtask

  initial begin
    idle();
    rst = 1;
    step();
    step();
    chk("rst_wmem_we", {31'd0, wmem_we}, 0);
    chk("rst_rd_valid", {31'd0, rd_valid}, 0);
    chk("rst_all_sealed", {31'd0, all_sealed}, 0);
    chk("rst_overflow", {31'd0, overflow}, 0);
    rst = 0;
    wr(6'd13, 5'h1A, 0, 0, 0, 0); step();
    wr(6'd17, 5'h01, 1, 3'd1, 3'd3, 0); step();
    wr(6'd20, 5'h02, 1, 3'd4, 3'd5, 0); step();
    wr(6'd22, 5'h03, 1, 3'd6, 3'd7, 0); step();
    wr(6'd23, 5'h04, 0, 0, 0, 1); step();
    rq(3'd2, 2'd3, 9'b110_100_001, 9'b111_101_011, 1); step();
    chk("ovf_before", {31'd0, overflow}, 0);
    wr(6'd18, 5'h05, 1, 3'd2, 3'd1, 0); step();
    chk("ovf_full_col", {31'd0, overflow}, 1);
    rq(3'd2, 2'd3, 9'b110_100_001, 9'b111_101_011, 1); step();
    clear = 1; step();
    chk("ovf_cleared", {31'd0, overflow}, 0);
    rq(3'd2, 2'd0, 9'd0, 9'd0, 0); step();
    wr(6'd7, 5'h06, 1, 3'd2, 3'd4, 1); step();
    rq(3'd0, 2'd1, 9'b000_000_010, 9'b000_000_100, 1); step();
    wr(6'd3, 5'h07, 1, 3'd3, 3'd1, 0); step();
    chk("ovf_sealed_col", {31'd0, overflow}, 1);
    rq(3'd0, 2'd1, 9'b000_000_010, 9'b000_000_100, 1); step();
    rq(3'd3, 2'd0, 9'd0, 9'd0, 0); step();
    for (int c = 1; c < 8; c++) begin
      wr({c[2:0], 3'd7}, 5'(c), 0, 0, 0, 1); step();
    end
    step();
    chk("all_sealed_set", {31'd0, all_sealed}, 1);
    clear = 1;
    wr(6'd41, 5'h11, 1, 3'd1, 3'd2, 0);
    rq(3'd0, 2'd1, 9'b000_000_010, 9'b000_000_100, 1);
    step();
    chk("all_sealed_clear", {31'd0, all_sealed}, 0);
    chk("ovf_clear_w_entry", {31'd0, overflow}, 0);
    rq(3'd5, 2'd0, 9'd0, 9'd0, 0); step();
    step();
    step();
    chk("wq_drained", wq.size(), 0);
    chk("rq_drained", rq_exp.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
